// File: rtl/crypto1_nlf_pkg.sv
// Crypto-1 non-linear filter tables, preimage helper functions and the
// enumerator state type shared by nlf_enum and nlf_preimage_rom.
package crypto1_nlf_pkg;

    localparam logic [15:0] NLF_FA = 16'h9E98;
    localparam logic [15:0] NLF_FB = 16'hB48E;
    localparam logic [31:0] NLF_FC = 32'hEC57E80A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_NONE
    } nlf_state_t;

    // Number of inputs x in [0, 2**nin) with fn[x] == b.
    function automatic int nlf_popcount(
        input logic [63:0] fn,
        input int          nin,
        input logic        b
    );
        int c;
        c = 0;
        for (int x = 0; x < (1 << nin); x++)
            if (fn[x] == b) c++;
        return c;
    endfunction

    // k-th (ascending, from 0) input x with fn[x] == b; 0 if none exists.
    function automatic int nlf_preimage(
        input logic [63:0] fn,
        input int          nin,
        input logic        b,
        input int          k
    );
        int c;
        int r;
        c = 0;
        r = 0;
        for (int x = 0; x < (1 << nin); x++) begin
            if (fn[x] == b) begin
                if (c == k) r = x;
                c++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nlf_preimage_rom.sv
// Elaboration-time lookup (b, idx) -> idx-th ascending preimage of b.
// Ports: b = requested bit, idx = preimage index, x = filter input vector.
module nlf_preimage_rom
    import crypto1_nlf_pkg::*;
#(
    parameter int               NIN = 4,
    parameter logic [2**NIN-1:0] FN = 16'hB48E,
    parameter int               IW  = $clog2(2**NIN + 1)
) (
    input  logic           b,
    input  logic [IW-1:0]  idx,
    output logic [NIN-1:0] x
);

    localparam int N = 2**NIN;

    logic [NIN-1:0] tab [2][N];

    for (genvar bb = 0; bb < 2; bb++) begin : g_bit
        for (genvar k = 0; k < N; k++) begin : g_ent
            assign tab[bb][k] =
                NIN'(nlf_preimage(64'(FN), NIN, 1'(bb), k));
        end
    end

    always_comb begin
        x = '0;
        for (int k = 0; k < N; k++)
            if (idx == IW'(k)) x = tab[b][k];
    end

endmodule

// File: rtl/nlf_enum.sv
// Streams every filter input vector producing REQ_BIT, ascending, one per
// cycle. Ports: CLK/RESET, REQ_* request side, OUT_* beat side, ABORT, BUSY.
module nlf_enum
    import crypto1_nlf_pkg::*;
#(
    parameter int               NIN = 4,
    parameter logic [2**NIN-1:0] FN = 16'hB48E
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           REQ_VALID,
    input  logic           REQ_BIT,
    output logic           REQ_READY,
    input  logic           ABORT,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [NIN-1:0] OUTPUT,
    output logic           OUT_LAST,
    output logic           OUT_NONE,
    output logic           BUSY
);

    localparam int IW   = $clog2(2**NIN + 1);
    localparam int CNT0 = nlf_popcount(64'(FN), NIN, 1'b0);
    localparam int CNT1 = nlf_popcount(64'(FN), NIN, 1'b1);

    nlf_state_t     state, n_state;
    logic           b_q, n_b;
    logic [IW-1:0]  idx_q, n_idx;
    logic [NIN-1:0] rom_x;
    logic [NIN-1:0] n_out;
    logic           n_last, n_none;
    logic           hs;
    logic [IW-1:0]  n_cnt;

    // ROM is addressed with the next (b, idx) so OUTPUT can be registered.
    nlf_preimage_rom #(
        .NIN (NIN),
        .FN  (FN),
        .IW  (IW)
    ) u_rom (
        .b   (n_b),
        .idx (n_idx),
        .x   (rom_x)
    );

    assign REQ_READY = (state == ST_IDLE) & ~ABORT;
    assign hs        = OUT_VALID & OUT_READY;
    assign n_cnt     = n_b ? IW'(CNT1) : IW'(CNT0);

    always_comb begin
        n_state = state;
        n_b     = b_q;
        n_idx   = idx_q;
        unique case (state)
            ST_IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    n_b   = REQ_BIT;
                    n_idx = '0;
                    if ((REQ_BIT ? CNT1 : CNT0) > 0)
                        n_state = ST_RUN;
                    else
                        n_state = ST_NONE;
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    n_state = ST_IDLE;
                    n_idx   = '0;
                end else if (hs) begin
                    if (OUT_LAST) begin
                        n_state = ST_IDLE;
                        n_idx   = '0;
                    end else begin
                        n_idx = idx_q + 1'b1;
                    end
                end
            end
            ST_NONE: begin
                if (ABORT || hs) n_state = ST_IDLE;
            end
            default: n_state = ST_IDLE;
        endcase

        n_out  = (n_state == ST_RUN) ? rom_x : '0;
        n_none = (n_state == ST_NONE);
        n_last = n_none ||
                 ((n_state == ST_RUN) && (n_idx == n_cnt - 1'b1));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            b_q       <= 1'b0;
            idx_q     <= '0;
            OUT_VALID <= 1'b0;
            OUTPUT    <= '0;
            OUT_LAST  <= 1'b0;
            OUT_NONE  <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state     <= n_state;
            b_q       <= n_b;
            idx_q     <= n_idx;
            OUT_VALID <= (n_state != ST_IDLE);
            OUTPUT    <= n_out;
            OUT_LAST  <= n_last;
            OUT_NONE  <= n_none;
            BUSY      <= (n_state != ST_IDLE);
        end
    end

endmodule
